cmd_controller: RTL and testbench

CMD_CONTROLLER -- requirements
Module: cmd_controller

---
 rtl/cmd_pkg.sv | 18 +
 rtl/cmd_vote.sv | 39 +++
 rtl/cmd_controller.sv | 152 +++++++++++++++
 tb/tb_cmd_controller.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_pkg.sv
// Shared opcode constants and controller state encoding.
package cmd_pkg;

  localparam int unsigned NIB_W = 4;

  localparam logic [NIB_W-1:0] OP_STOP  = 4'h0;
  localparam logic [NIB_W-1:0] OP_START = 4'hF;
  localparam logic [NIB_W-1:0] OP_GATED = 4'h3;
  localparam logic [NIB_W-1:0] OP_READ  = 4'h5;
  localparam logic [NIB_W-1:0] OP_CLEAR = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_GATED = 2'd2
  } state_e;

endpackage : cmd_pkg

// File: rtl/cmd_vote.sv
// Nibble majority vote: a command word is accepted when all but at most one
// nibble agree; the agreeing nibble value is the opcode.
module cmd_vote
  import cmd_pkg::*;
#(
  parameter int unsigned CMD_W = 16
) (
  input  logic [CMD_W-1:0] cmd,
  output logic [NIB_W-1:0] opcode_c,
  output logic             valid_c
);

  localparam int unsigned N_NIB = CMD_W / NIB_W;
  localparam int unsigned THR   = N_NIB - 1;
  localparam int unsigned CNT_W = $clog2(N_NIB + 1);

  logic [N_NIB-1:0][NIB_W-1:0] nib;
  logic [CNT_W-1:0]            cnt;

  assign nib = cmd;

  // Count agreement for each nibble; scan high to low so the lowest-index winner is kept.
  always_comb begin
    opcode_c = '0;
    valid_c  = 1'b0;
    cnt      = '0;
    for (int i = int'(N_NIB) - 1; i >= 0; i--) begin
      cnt = '0;
      for (int j = 0; j < int'(N_NIB); j++) begin
        if (nib[j] == nib[i]) cnt = cnt + CNT_W'(1);
      end
      if (cnt >= CNT_W'(THR)) begin
        opcode_c = nib[i];
        valid_c  = 1'b1;
      end
    end
  end

endmodule : cmd_vote

// File: rtl/cmd_controller.sv
// Command-driven counter gate controller: free-run and timed-gate counting,
// readout/clear pulses, and error flagging for rejected commands.
module cmd_controller
  import cmd_pkg::*;
#(
  parameter int unsigned CMD_W  = 16,
  parameter int unsigned N_CH   = 4,
  parameter int unsigned GATE_W = 24
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CMD_VALID,
  input  logic [CMD_W-1:0]  COMMAND,
  input  logic [N_CH-1:0]   CH_MASK,
  input  logic [GATE_W-1:0] GATE_LEN,
  output logic [N_CH-1:0]   START_COUNT,
  output logic              READ_DATA,
  output logic              CLEAR_COUNT,
  output logic              GATE_DONE,
  output logic              CMD_ERR,
  output logic              BUSY
);

  state_e              state_q, state_d;
  logic [GATE_W-1:0]   timer_q, timer_d;
  logic [N_CH-1:0]     start_count_q, start_count_d;
  logic                read_data_q, read_data_d;
  logic                clear_count_q, clear_count_d;
  logic                gate_done_q, gate_done_d;
  logic                cmd_err_q, cmd_err_d;
  logic                busy_q, busy_d;

  logic [NIB_W-1:0]    opcode_c;
  logic                vote_ok_c;
  logic                is_stop_c;

  cmd_vote #(.CMD_W(CMD_W)) u_vote (
    .cmd      (COMMAND),
    .opcode_c (opcode_c),
    .valid_c  (vote_ok_c)
  );

  assign is_stop_c = CMD_VALID && vote_ok_c && (opcode_c == OP_STOP);

  // Next-state and output decode.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    start_count_d = start_count_q;
    read_data_d   = 1'b0;
    clear_count_d = 1'b0;
    gate_done_d   = 1'b0;
    cmd_err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID) begin
          if (!vote_ok_c) begin
            cmd_err_d = 1'b1;
          end else begin
            case (opcode_c)
              OP_STOP: ;
              OP_START: begin
                state_d       = ST_COUNT;
                start_count_d = CH_MASK;
              end
              OP_GATED: begin
                if (GATE_LEN == '0) begin
                  cmd_err_d = 1'b1;
                end else begin
                  state_d       = ST_GATED;
                  timer_d       = GATE_LEN;
                  start_count_d = CH_MASK;
                end
              end
              OP_READ:  read_data_d   = 1'b1;
              OP_CLEAR: clear_count_d = 1'b1;
              default:  cmd_err_d     = 1'b1;
            endcase
          end
        end
      end

      ST_COUNT: begin
        if (is_stop_c) begin
          state_d       = ST_IDLE;
          start_count_d = '0;
        end else if (CMD_VALID) begin
          cmd_err_d = 1'b1;
        end
      end

      ST_GATED: begin
        // An explicit stop wins over natural expiry and suppresses GATE_DONE.
        if (is_stop_c) begin
          state_d       = ST_IDLE;
          start_count_d = '0;
          timer_d       = '0;
        end else begin
          if (CMD_VALID) cmd_err_d = 1'b1;
          if (timer_q == GATE_W'(1)) begin
            state_d       = ST_IDLE;
            start_count_d = '0;
            timer_d       = '0;
            gate_done_d   = 1'b1;
          end else begin
            timer_d = timer_q - GATE_W'(1);
          end
        end
      end

      default: begin
        state_d       = ST_IDLE;
        timer_d       = '0;
        start_count_d = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      start_count_q <= '0;
      read_data_q   <= 1'b0;
      clear_count_q <= 1'b0;
      gate_done_q   <= 1'b0;
      cmd_err_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      start_count_q <= start_count_d;
      read_data_q   <= read_data_d;
      clear_count_q <= clear_count_d;
      gate_done_q   <= gate_done_d;
      cmd_err_q     <= cmd_err_d;
      busy_q        <= busy_d;
    end
  end

  assign START_COUNT = start_count_q;
  assign READ_DATA   = read_data_q;
  assign CLEAR_COUNT = clear_count_q;
  assign GATE_DONE   = gate_done_q;
  assign CMD_ERR     = cmd_err_q;
  assign BUSY        = busy_q;

endmodule : cmd_controller

// File: tb/tb_cmd_controller.sv
// Bench for cmd_controller: directed scenarios plus random commands checked
// against a cycle-level behavioural model.
module tb_cmd_controller;

  localparam int unsigned CMD_W  = 16;
  localparam int unsigned N_CH   = 4;
  localparam int unsigned GATE_W = 24;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              CMD_VALID = 1'b0;
  logic [CMD_W-1:0]  COMMAND = '0;
  logic [N_CH-1:0]   CH_MASK = '0;
  logic [GATE_W-1:0] GATE_LEN = '0;
  logic [N_CH-1:0]   START_COUNT;
  logic              READ_DATA, CLEAR_COUNT, GATE_DONE, CMD_ERR, BUSY;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: running flag, gated flag, cycles of gate left.
  bit              m_run, m_gated;
  int              m_left;
  logic [N_CH-1:0] e_sc;
  bit              e_rd, e_clr, e_done, e_err;

  cmd_controller #(.CMD_W(CMD_W), .N_CH(N_CH), .GATE_W(GATE_W)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .CMD_VALID   (CMD_VALID),
    .COMMAND     (COMMAND),
    .CH_MASK     (CH_MASK),
    .GATE_LEN    (GATE_LEN),
    .START_COUNT (START_COUNT),
    .READ_DATA   (READ_DATA),
    .CLEAR_COUNT (CLEAR_COUNT),
    .GATE_DONE   (GATE_DONE),
    .CMD_ERR     (CMD_ERR),
    .BUSY        (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Histogram vote: opcode is any nibble value appearing at least 3 of 4 times.
  function automatic void decode(input logic [15:0] w, output bit ok, output logic [3:0] op);
    int hist [16];
    logic [3:0] nb;
    for (int v = 0; v < 16; v++) hist[v] = 0;
    for (int k = 0; k < 4; k++) begin
      nb = w[4*k +: 4];
      hist[nb]++;
    end
    ok = 1'b0;
    op = 4'h0;
    for (int v = 0; v < 16; v++) begin
      if (hist[v] >= 3) begin
        ok = 1'b1;
        op = 4'(v);
      end
    end
  endfunction

  function automatic void model(input bit rst, input bit v, input logic [15:0] cmd,
                                input logic [3:0] mask, input logic [23:0] glen);
    bit ok;
    logic [3:0] op;
    e_rd = 0; e_clr = 0; e_done = 0; e_err = 0;
    if (rst) begin
      m_run = 0; m_gated = 0; m_left = 0; e_sc = '0;
      return;
    end
    decode(cmd, ok, op);
    if (!m_run) begin
      if (v) begin
        if (!ok) e_err = 1;
        else if (op == 4'hF) begin m_run = 1; m_gated = 0; e_sc = mask; end
        else if (op == 4'h3) begin
          if (glen == 0) e_err = 1;
          else begin m_run = 1; m_gated = 1; m_left = int'(glen); e_sc = mask; end
        end
        else if (op == 4'h5) e_rd = 1;
        else if (op == 4'hA) e_clr = 1;
        else if (op != 4'h0) e_err = 1;
      end
    end else if (v && ok && op == 4'h0) begin
      m_run = 0; m_gated = 0; m_left = 0; e_sc = '0;
    end else begin
      if (v) e_err = 1;
      if (m_gated) begin
        m_left--;
        if (m_left == 0) begin
          m_run = 0; m_gated = 0; e_sc = '0; e_done = 1;
        end
      end
    end
  endfunction

  // One clock: drive on falling edge, model at rising edge, compare just after.
  task automatic step(input bit rst, input bit v, input logic [15:0] cmd,
                      input logic [3:0] mask, input logic [23:0] glen);
    @(negedge CLK);
    RST = rst; CMD_VALID = v; COMMAND = cmd; CH_MASK = mask; GATE_LEN = glen;
    @(posedge CLK);
    model(rst, v, cmd, mask, glen);
    #1;
    check("start_count", 32'(START_COUNT), 32'(e_sc));
    check("read_data",   32'(READ_DATA),   32'(e_rd));
    check("clear_count", 32'(CLEAR_COUNT), 32'(e_clr));
    check("gate_done",   32'(GATE_DONE),   32'(e_done));
    check("cmd_err",     32'(CMD_ERR),     32'(e_err));
    check("busy",        32'(BUSY),        32'(m_run));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 16'h0000, 4'hF, 24'd7);
  endtask

  initial begin
    int hi_cnt;
    int done_cnt;
    logic [15:0] w;
    logic [3:0] nb;
    int r;

    step(1, 0, 16'h0000, 4'h0, 24'd0);
    step(1, 1, 16'hFFFF, 4'hF, 24'd0);
    check("rst_busy", 32'(BUSY), 32'd0);

    // Free run start/stop.
    step(0, 1, 16'hFFFF, 4'b1011, 24'd0);
    check("run_mask", 32'(START_COUNT), 32'hB);
    check("run_busy", 32'(BUSY), 32'd1);
    step(0, 1, 16'h0000, 4'b0000, 24'd0);
    check("stop_sc", 32'(START_COUNT), 32'h0);

    // One-nibble-corrupt words.
    step(0, 1, 16'hF7FF, 4'b0110, 24'd0);
    check("f7ff_sc", 32'(START_COUNT), 32'h6);
    step(0, 1, 16'h00A0, 4'b0000, 24'd0);
    check("00a0_busy", 32'(BUSY), 32'd0);
    step(0, 1, 16'hF0F0, 4'hF, 24'd0);
    check("f0f0_err", 32'(CMD_ERR), 32'd1);
    check("f0f0_sc", 32'(START_COUNT), 32'h0);

    // Gated run of 5.
    step(0, 1, 16'h3333, 4'b1111, 24'd5);
    hi_cnt = (START_COUNT != 0) ? 1 : 0;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 16'h0000, 4'h1, 24'd9);
      if (START_COUNT != 0) hi_cnt++;
      if (GATE_DONE) done_cnt++;
    end
    check("gate5_high", 32'(hi_cnt), 32'd5);
    check("gate5_done", 32'(done_cnt), 32'd1);
    check("gate5_busy", 32'(BUSY), 32'd0);

    // Gated run of 3 stopped in its final cycle.
    step(0, 1, 16'h3333, 4'b0101, 24'd3);
    idle(2);
    step(0, 1, 16'h0000, 4'h0, 24'd0);
    check("gate3_done", 32'(GATE_DONE), 32'd0);
    check("gate3_busy", 32'(BUSY), 32'd0);
    idle(2);

    // Zero-length gate rejected.
    step(0, 1, 16'h3333, 4'hF, 24'd0);
    check("glen0_err", 32'(CMD_ERR), 32'd1);

    // Read/clear pulses.
    step(0, 1, 16'h5555, 4'h0, 24'd0);
    check("read_idle", 32'(READ_DATA), 32'd1);
    idle(1);
    check("read_pulse", 32'(READ_DATA), 32'd0);
    step(0, 1, 16'hFFFF, 4'h3, 24'd0);
    step(0, 1, 16'h5555, 4'h0, 24'd0);
    check("read_busy_err", 32'(CMD_ERR), 32'd1);
    check("read_busy_rd", 32'(READ_DATA), 32'd0);
    step(0, 1, 16'h0000, 4'h0, 24'd0);
    step(0, 1, 16'hAAAA, 4'h0, 24'd0);
    check("clear_idle", 32'(CLEAR_COUNT), 32'd1);

    // Reset mid-gate.
    step(0, 1, 16'h3333, 4'hF, 24'd100);
    idle(39);
    step(1, 0, 16'h0000, 4'h0, 24'd0);
    check("midrst_sc", 32'(START_COUNT), 32'h0);
    check("midrst_busy", 32'(BUSY), 32'd0);
    step(0, 0, 16'hFFFF, 4'hF, 24'd0);
    step(0, 0, 16'h5555, 4'hF, 24'd0);
    check("novalid_rd", 32'(READ_DATA), 32'd0);
    check("novalid_busy", 32'(BUSY), 32'd0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      r = int'($urandom_range(0, 9));
      case ($urandom_range(0, 5))
        0: nb = 4'h0;
        1: nb = 4'hF;
        2: nb = 4'h3;
        3: nb = 4'h5;
        4: nb = 4'hA;
        default: nb = 4'($urandom);
      endcase
      w = {nb, nb, nb, nb};
      if (r >= 6 && r <= 7) w[4*$urandom_range(0, 3) +: 4] = 4'($urandom);
      else if (r >= 8) w = 16'($urandom);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0, w,
           4'($urandom), 24'($urandom_range(0, 12)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_cmd_controller
